uart_mem_access_sequencer: RTL and testbench

Executes host commands decoded from the UART receive path (read or write of one 32-bit word in one of several on-chip memories). It shares each memory port with the GPU core, preempting the core only when the core is idle or starving the UART. It then returns a response to the host through the UART transmitter byte handshake. It sits between the UART command decoder and the memory/UART TX blocks.

---
 rtl/uart_mem_access_sequencer_pkg.sv | 32 +++
 rtl/uart_mem_access_sequencer_serializer.sv | 56 +++++
 rtl/uart_mem_access_sequencer.sv | 135 +++++++++++++
 tb/tb_uart_mem_access_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mem_access_sequencer_pkg.sv
// Shared constants for the UART memory-access sequencer: command codes,
// response bytes, state encodings and datapath widths.
package uart_mem_access_sequencer_pkg;

  localparam logic UART_WRITE = 1'b1;
  localparam logic UART_READ  = 1'b0;

  localparam int GPU_WORD  = 32;
  localparam int UART_BYTE = 8;

  localparam logic [UART_BYTE-1:0] ACK_WRITE = 8'hAA;
  localparam logic [UART_BYTE-1:0] ERR_DEV   = 8'hEE;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_BUS = 3'd1;
  localparam logic [2:0] ST_ACCESS   = 3'd2;
  localparam logic [2:0] ST_CAPTURE  = 3'd3;
  localparam logic [2:0] ST_TX_START = 3'd4;
  localparam logic [2:0] ST_TX_ACK   = 3'd5;
  localparam logic [2:0] ST_TX_DONE  = 3'd6;

  function automatic logic [UART_BYTE-1:0] wordByte(input logic [GPU_WORD-1:0] word,
                                                    input logic [1:0] idx);
    case (idx)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

endpackage

// File: rtl/uart_mem_access_sequencer_serializer.sv
// Sends a 1-4 byte response LSB first over the UART TX start/busy handshake.
// state     | meaning
// IDLE      | no response pending, accepts iLoad
// TX_START  | waiting for transmitter idle, then pulses oTxStart
// TX_ACK    | waiting for transmitter to report busy
// TX_DONE   | waiting for transmitter to finish the byte
module uart_response_serializer
  import uart_mem_access_sequencer_pkg::*;
(
  input  logic                 iClock,
  input  logic                 iReset,
  input  logic                 iLoad,
  input  logic [GPU_WORD-1:0]  iWord,
  input  logic [2:0]           iByteCount,
  input  logic                 iTxBusy,
  output logic [UART_BYTE-1:0] oTxByte,
  output logic                 oTxStart,
  output logic                 oDone
);

  logic [2:0]          txState;
  logic [GPU_WORD-1:0] word;
  logic [2:0]          remaining;
  logic [1:0]          byteIndex;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      txState   <= ST_IDLE;
      word      <= '0;
      remaining <= '0;
      byteIndex <= '0;
    end else begin
      case (txState)
        ST_IDLE: if (iLoad) begin
          word      <= iWord;
          remaining <= iByteCount;
          byteIndex <= '0;
          txState   <= ST_TX_START;
        end
        ST_TX_START: if (!iTxBusy) txState <= ST_TX_ACK;
        ST_TX_ACK:   if (iTxBusy) txState <= ST_TX_DONE;
        ST_TX_DONE: if (!iTxBusy) begin
          remaining <= remaining - 3'd1;
          byteIndex <= byteIndex + 2'd1;
          txState   <= (remaining == 3'd1) ? ST_IDLE : ST_TX_START;
        end
        default: txState <= ST_IDLE;
      endcase
    end
  end

  assign oTxByte  = wordByte(word, byteIndex);
  assign oTxStart = (txState == ST_TX_START) && !iTxBusy && !iReset;
  assign oDone    = (txState == ST_TX_DONE) && !iTxBusy && (remaining == 3'd1);

endmodule

// File: rtl/uart_mem_access_sequencer.sv
// Executes one-word UART read/write commands on shared on-chip memories,
// arbitrating against the GPU core, and hands the response to the serializer.
// state     | meaning
// IDLE      | waiting for a command
// WAIT_BUS  | waiting for the core to release the ports or starvation limit
// ACCESS    | one-cycle memory strobe, core grant withheld
// CAPTURE   | read data sampled and loaded into the serializer
// TX_START  | response owned by the serializer (TX_START/TX_ACK/TX_DONE)
module uart_mem_access_sequencer
  import uart_mem_access_sequencer_pkg::*;
#(
  parameter int NUM_DEV      = 4,
  parameter int DEV_ADDR_SZ  = 3,
  parameter int MEM_ADDR_SZ  = 16,
  parameter int STARVE_LIMIT = 255
) (
  input  logic                        iClock,
  input  logic                        iReset,
  input  logic                        iIssueCommand,
  input  logic                        iUartCommand,
  input  logic [DEV_ADDR_SZ-1:0]      iDeviceAddress,
  input  logic [MEM_ADDR_SZ-1:0]      iMemoryAddress,
  input  logic [GPU_WORD-1:0]         iWriteData,
  input  logic                        iCoreReq,
  output logic                        oCoreGrant,
  output logic [MEM_ADDR_SZ-1:0]      oMemAddress,
  output logic [GPU_WORD-1:0]         oMemWriteData,
  output logic [NUM_DEV-1:0]          oMemWriteEnable,
  output logic [NUM_DEV-1:0]          oMemReadEnable,
  input  logic [NUM_DEV*GPU_WORD-1:0] iMemReadData,
  output logic [UART_BYTE-1:0]        oTxByte,
  output logic                        oTxStart,
  input  logic                        iTxBusy,
  output logic                        oBusy,
  output logic                        oOverrun
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [2:0]             state;
  logic                   cmdWrite;
  logic [DEV_ADDR_SZ-1:0] devAddr;
  logic [STARVE_W-1:0]    starveCount;
  logic [STARVE_W-1:0]    starveNext;
  logic                   devValid;
  logic [NUM_DEV-1:0]     strobe;
  logic [GPU_WORD-1:0]    readSlice;
  logic                   serLoad;
  logic [GPU_WORD-1:0]    serWord;
  logic [2:0]             serCount;
  logic                   serDone;

  assign devValid   = 32'(iDeviceAddress) < NUM_DEV;
  assign starveNext = (starveCount == {STARVE_W{1'b1}}) ? starveCount : starveCount + 1'b1;
  assign oBusy      = (state != ST_IDLE);
  assign oCoreGrant = iCoreReq && (state != ST_ACCESS) && (state != ST_CAPTURE);

  // Gated by iReset so an abort never leaves a strobe in the reset cycle.
  assign strobe          = (state == ST_ACCESS && !iReset) ? (NUM_DEV'(1'b1) << devAddr) : '0;
  assign oMemWriteEnable = (cmdWrite == UART_WRITE) ? strobe : '0;
  assign oMemReadEnable  = (cmdWrite == UART_READ)  ? strobe : '0;

  always_comb begin
    readSlice = '0;
    for (int d = 0; d < NUM_DEV; d++)
      if (devAddr == DEV_ADDR_SZ'(d)) readSlice = iMemReadData[GPU_WORD*d +: GPU_WORD];
  end

  always_comb begin
    serLoad  = 1'b0;
    serWord  = '0;
    serCount = 3'd1;
    case (state)
      ST_IDLE: if (iIssueCommand && !devValid) begin
        serLoad = 1'b1;
        serWord = GPU_WORD'(ERR_DEV);
      end
      ST_ACCESS: if (cmdWrite == UART_WRITE) begin
        serLoad = 1'b1;
        serWord = GPU_WORD'(ACK_WRITE);
      end
      ST_CAPTURE: begin
        serLoad  = 1'b1;
        serWord  = readSlice;
        serCount = 3'd4;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state         <= ST_IDLE;
      cmdWrite      <= 1'b0;
      devAddr       <= '0;
      oMemAddress   <= '0;
      oMemWriteData <= '0;
      starveCount   <= '0;
      oOverrun      <= 1'b0;
    end else begin
      if (iIssueCommand && oBusy) oOverrun <= 1'b1;
      case (state)
        ST_IDLE: if (iIssueCommand) begin
          cmdWrite      <= iUartCommand;
          devAddr       <= iDeviceAddress;
          oMemAddress   <= iMemoryAddress;
          oMemWriteData <= iWriteData;
          starveCount   <= '0;
          state         <= devValid ? ST_WAIT_BUS : ST_TX_START;
        end
        // starveNext counts the current cycle, giving STARVE_LIMIT wait cycles.
        ST_WAIT_BUS:
          if (!iCoreReq || starveNext == STARVE_W'(STARVE_LIMIT)) state <= ST_ACCESS;
          else starveCount <= starveNext;
        ST_ACCESS:   state <= (cmdWrite == UART_WRITE) ? ST_TX_START : ST_CAPTURE;
        ST_CAPTURE:  state <= ST_TX_START;
        ST_TX_START: if (serDone) state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

  uart_response_serializer uSerializer (
    .iClock    (iClock),
    .iReset    (iReset),
    .iLoad     (serLoad),
    .iWord     (serWord),
    .iByteCount(serCount),
    .iTxBusy   (iTxBusy),
    .oTxByte   (oTxByte),
    .oTxStart  (oTxStart),
    .oDone     (serDone)
  );

endmodule

// File: tb/tb_uart_mem_access_sequencer.sv
// Directed bench: command vector table plus starvation, overrun and reset sequences,
// with a bench-side memory and UART transmitter model.
module tb_uart_mem_access_sequencer;

  logic         iClock = 1'b0;
  logic         iReset = 1'b1;
  logic         iIssueCommand = 1'b0;
  logic         iUartCommand = 1'b0;
  logic [2:0]   iDeviceAddress = '0;
  logic [15:0]  iMemoryAddress = '0;
  logic [31:0]  iWriteData = '0;
  logic         iCoreReq = 1'b0;
  logic         oCoreGrant;
  logic [15:0]  oMemAddress;
  logic [31:0]  oMemWriteData;
  logic [3:0]   oMemWriteEnable;
  logic [3:0]   oMemReadEnable;
  logic [127:0] memRd = {32'hD3D3D3D3, 32'hD2D2D2D2, 32'hD1D1D1D1, 32'hD0D0D0D0};
  logic [7:0]   oTxByte;
  logic         oTxStart;
  logic         iTxBusy = 1'b0;
  logic         oBusy;
  logic         oOverrun;

  uart_mem_access_sequencer dut (
    .iClock(iClock), .iReset(iReset), .iIssueCommand(iIssueCommand),
    .iUartCommand(iUartCommand), .iDeviceAddress(iDeviceAddress),
    .iMemoryAddress(iMemoryAddress), .iWriteData(iWriteData), .iCoreReq(iCoreReq),
    .oCoreGrant(oCoreGrant), .oMemAddress(oMemAddress), .oMemWriteData(oMemWriteData),
    .oMemWriteEnable(oMemWriteEnable), .oMemReadEnable(oMemReadEnable),
    .iMemReadData(memRd), .oTxByte(oTxByte), .oTxStart(oTxStart), .iTxBusy(iTxBusy),
    .oBusy(oBusy), .oOverrun(oOverrun)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    logic        wr;
    logic [2:0]  dev;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  expWe;
    logic [3:0]  expRe;
    int          nBytes;
    logic [7:0]  b [4];
    int          strobeLat;
    int          startLat;
  } vec_t;

  vec_t vecs[10];
  int checks = 0;
  int failures = 0;

  logic [31:0] mem [4][32];
  int cycleNum = 0, issueCycle = -1, weCycle = -1, reCycle = -1, startCycle = -1;
  int weCount, reCount, grantLow, txPhase = 0;
  logic [3:0]  lastWe, lastRe;
  logic [15:0] lastAddr;
  logic [31:0] lastData;
  logic        weGrant, postGrant;
  logic [7:0]  txBytes[$];

  // Memory, transmitter and event monitor all act on the falling edge.
  always @(negedge iClock) begin
    cycleNum++;
    if (iIssueCommand && !oBusy && !iReset) issueCycle = cycleNum;
    if (oMemWriteEnable != 0) begin
      weCount++; lastWe = oMemWriteEnable; lastAddr = oMemAddress; lastData = oMemWriteData;
      weGrant = oCoreGrant;
      if (weCycle < 0) weCycle = cycleNum;
      for (int d = 0; d < 4; d++) if (oMemWriteEnable[d]) mem[d][oMemAddress[4:0]] = oMemWriteData;
    end
    if (oMemReadEnable != 0) begin
      reCount++; lastRe = oMemReadEnable;
      if (reCycle < 0) reCycle = cycleNum;
      for (int d = 0; d < 4; d++) if (oMemReadEnable[d]) memRd[32*d +: 32] = mem[d][oMemAddress[4:0]];
    end
    if (weCycle >= 0 && cycleNum == weCycle + 1) postGrant = oCoreGrant;
    if (iCoreReq && !oCoreGrant) grantLow++;
    if (oTxStart) begin
      txBytes.push_back(oTxByte);
      if (startCycle < 0) startCycle = cycleNum;
      txPhase = 4;
    end else if (txPhase != 0) txPhase--;
    iTxBusy = (txPhase >= 1 && txPhase <= 3);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clearStats();
    weCount = 0; reCount = 0; grantLow = 0;
    weCycle = -1; reCycle = -1; startCycle = -1; issueCycle = -1;
    lastWe = '0; lastRe = '0; lastAddr = '0; lastData = '0;
    weGrant = 1'b1; postGrant = 1'b0;
    txBytes.delete();
  endtask

  task automatic issue(input logic wr, input logic [2:0] dev, input logic [15:0] addr,
                       input logic [31:0] data);
    @(posedge iClock); #1;
    iUartCommand = wr; iDeviceAddress = dev; iMemoryAddress = addr; iWriteData = data;
    iIssueCommand = 1'b1;
    @(posedge iClock); #1;
    iIssueCommand = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    int n;
    for (n = 0; n < 2000; n++) begin
      if (!oBusy) break;
      @(posedge iClock); #1;
    end
    check({tag, "_done_in_time"}, 32'(n < 2000), 32'd1);
  endtask

  task automatic applyVec(input vec_t v, input string tag);
    clearStats();
    issue(v.wr, v.dev, v.addr, v.data);
    waitIdle(tag);
    check({tag, "_we_count"}, weCount, (v.expWe != 0) ? 1 : 0);
    check({tag, "_re_count"}, reCount, (v.expRe != 0) ? 1 : 0);
    if (v.expWe != 0) begin
      check({tag, "_we"}, lastWe, v.expWe);
      check({tag, "_addr"}, lastAddr, v.addr);
      check({tag, "_data"}, lastData, v.data);
    end
    if (v.expRe != 0) check({tag, "_re"}, lastRe, v.expRe);
    if (v.strobeLat >= 0)
      check({tag, "_strobe_lat"}, ((v.expWe != 0) ? weCycle : reCycle) - issueCycle, v.strobeLat);
    check({tag, "_start_lat"}, startCycle - issueCycle, v.startLat);
    check({tag, "_nbytes"}, txBytes.size(), v.nBytes);
    for (int i = 0; i < v.nBytes && i < txBytes.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), txBytes[i], v.b[i]);
  endtask

  function automatic vec_t mk(input logic wr, input logic [2:0] dev, input logic [15:0] addr,
                              input logic [31:0] data, input logic [3:0] we, input logic [3:0] re,
                              input int nb, input logic [31:0] bytesLsbFirst, input int sl,
                              input int st);
    vec_t v;
    v.wr = wr; v.dev = dev; v.addr = addr; v.data = data; v.expWe = we; v.expRe = re;
    v.nBytes = nb; v.strobeLat = sl; v.startLat = st;
    for (int i = 0; i < 4; i++) v.b[i] = bytesLsbFirst[8*i +: 8];
    return v;
  endfunction

  initial begin
    int n;
    vecs[0] = mk(1, 3'd1, 16'h0010, 32'h12345678, 4'b0010, 4'b0000, 1, 32'h000000AA, 2, 3);
    vecs[1] = mk(1, 3'd2, 16'h0003, 32'hCAFEBABE, 4'b0100, 4'b0000, 1, 32'h000000AA, 2, 3);
    vecs[2] = mk(0, 3'd2, 16'h0003, 32'h0,        4'b0000, 4'b0100, 4, 32'hCAFEBABE, 2, 4);
    vecs[3] = mk(0, 3'd1, 16'h0010, 32'h0,        4'b0000, 4'b0010, 4, 32'h12345678, 2, 4);
    vecs[4] = mk(1, 3'd5, 16'h0001, 32'h11111111, 4'b0000, 4'b0000, 1, 32'h000000EE, -1, 1);
    vecs[5] = mk(0, 3'd4, 16'h0002, 32'h0,        4'b0000, 4'b0000, 1, 32'h000000EE, -1, 1);
    vecs[6] = mk(1, 3'd3, 16'hFFFF, 32'h00C0FFEE, 4'b1000, 4'b0000, 1, 32'h000000AA, 2, 3);
    vecs[7] = mk(0, 3'd3, 16'hFFFF, 32'h0,        4'b0000, 4'b1000, 4, 32'h00C0FFEE, 2, 4);
    vecs[8] = mk(1, 3'd0, 16'h0000, 32'hA5A50001, 4'b0001, 4'b0000, 1, 32'h000000AA, 2, 3);
    vecs[9] = mk(0, 3'd0, 16'h0000, 32'h0,        4'b0000, 4'b0001, 4, 32'hA5A50001, 2, 4);
    for (int d = 0; d < 4; d++) for (int a = 0; a < 32; a++) mem[d][a] = 32'h0BAD0000 | 32'(a);

    repeat (3) @(posedge iClock);
    #1;
    check("rst_grant", oCoreGrant, 0);
    check("rst_addr", oMemAddress, 0);
    check("rst_wdata", oMemWriteData, 0);
    check("rst_we", oMemWriteEnable, 0);
    check("rst_re", oMemReadEnable, 0);
    check("rst_txbyte", oTxByte, 0);
    check("rst_txstart", oTxStart, 0);
    check("rst_busy", oBusy, 0);
    check("rst_overrun", oOverrun, 0);
    iReset = 1'b0;

    for (int i = 0; i < 10; i++) applyVec(vecs[i], $sformatf("v%0d", i));
    check("no_overrun_yet", oOverrun, 0);

    // Core holds the bus: forced access after the starvation limit.
    clearStats();
    iCoreReq = 1'b1;
    issue(1, 3'd0, 16'h0005, 32'h55AA0005);
    waitIdle("starve");
    check("starve_strobe_lat", weCycle - issueCycle, 256);
    check("starve_we", lastWe, 4'b0001);
    check("starve_grant_low_cycles", grantLow, 1);
    check("starve_grant_at_strobe", weGrant, 0);
    check("starve_grant_after", postGrant, 1);
    check("starve_byte", (txBytes.size() > 0) ? txBytes[0] : 8'h00, 8'hAA);
    iCoreReq = 1'b0;

    // Second command while the read response is being sent.
    clearStats();
    issue(0, 3'd2, 16'h0003, 32'h0);
    for (n = 0; n < 200 && txBytes.size() < 1; n++) begin @(posedge iClock); #1; end
    check("ovr_first_byte_seen", 32'(n < 200), 1);
    issue(1, 3'd0, 16'h0007, 32'h11111111);
    waitIdle("ovr");
    repeat (20) @(posedge iClock);
    #1;
    check("ovr_flag", oOverrun, 1);
    check("ovr_no_write", weCount, 0);
    check("ovr_re_count", reCount, 1);
    check("ovr_nbytes", txBytes.size(), 4);
    if (txBytes.size() == 4) begin
      check("ovr_b0", txBytes[0], 8'hBE);
      check("ovr_b1", txBytes[1], 8'hBA);
      check("ovr_b2", txBytes[2], 8'hFE);
      check("ovr_b3", txBytes[3], 8'hCA);
    end

    // Reset while the serializer waits in TX_ACK.
    clearStats();
    issue(0, 3'd1, 16'h0010, 32'h0);
    for (n = 0; n < 200 && txBytes.size() < 1; n++) begin @(posedge iClock); #1; end
    check("rst_mid_first_byte_seen", 32'(n < 200), 1);
    iReset = 1'b1;
    @(posedge iClock); #1;
    iReset = 1'b0;
    check("midrst_we", oMemWriteEnable, 0);
    check("midrst_re", oMemReadEnable, 0);
    check("midrst_txstart", oTxStart, 0);
    check("midrst_txbyte", oTxByte, 0);
    check("midrst_busy", oBusy, 0);
    check("midrst_overrun", oOverrun, 0);
    check("midrst_addr", oMemAddress, 0);
    check("midrst_wdata", oMemWriteData, 0);
    check("midrst_grant", oCoreGrant, 0);
    repeat (8) @(posedge iClock);
    check("midrst_bytes_stopped", txBytes.size(), 1);
    applyVec(vecs[0], "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
